// File: rtl/sram_2rw_param.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// sram_2rw_param
//   Dual-port (two read/write ports) synchronous SRAM with per-granule write
//   masks and a configurable registered read latency (RD_LAT = 1 or 2).
//   Reads are read-first. On a same-address dual write, RW0 owns every granule
//   in its mask and RW1 fills only the granules RW0 leaves alone.
//
//   Optional feature macro: SRAM_2RW_PARAM_INIT_EN
//     defined   : after reset, an INIT sweep writes zero to every word
//                 (DEPTH cycles, init_busy high) before any access is taken.
//     undefined : no sweep, init_busy tied low, memory powers up undefined.
//
// Ports
//   clock               sole clock, all state on the rising edge
//   reset               synchronous, active-high
//   init_busy           zeroing sweep in progress (accesses are dropped)
//   RWp_addr  [ADDR_W]  word address (p = 0,1)
//   RWp_en              access enable
//   RWp_wmode           1 = write, 0 = read
//   RWp_wmask [MASK_W]  per-granule write enable, granule = WIDTH/MASK_W bits
//   RWp_wdata [WIDTH]   write data
//   RWp_rdata [WIDTH]   registered read data, holds between reads
//   RWp_rvalid          one-cycle pulse when RWp_rdata carries a new read
//   wr_conflict         pulses one cycle after a same-address dual write with
//                       overlapping masks
// -----------------------------------------------------------------------------
module sram_2rw_param #(
  parameter int DEPTH  = 256,
  parameter int WIDTH  = 36,
  parameter int ADDR_W = 8,
  parameter int MASK_W = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  output logic              init_busy,

  input  logic [ADDR_W-1:0] RW0_addr,
  input  logic              RW0_en,
  input  logic              RW0_wmode,
  input  logic [MASK_W-1:0] RW0_wmask,
  input  logic [WIDTH-1:0]  RW0_wdata,
  output logic [WIDTH-1:0]  RW0_rdata,
  output logic              RW0_rvalid,

  input  logic [ADDR_W-1:0] RW1_addr,
  input  logic              RW1_en,
  input  logic              RW1_wmode,
  input  logic [MASK_W-1:0] RW1_wmask,
  input  logic [WIDTH-1:0]  RW1_wdata,
  output logic [WIDTH-1:0]  RW1_rdata,
  output logic              RW1_rvalid,

  output logic              wr_conflict
);

  localparam int G     = WIDTH / MASK_W;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // DEPTH may equal 2^ADDR_W, so the range compare needs one extra bit.
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Per-port views so both ports share one generate body.
  logic [ADDR_W-1:0] w_addr  [2];
  logic              w_en    [2];
  logic              w_wmode [2];
  logic [MASK_W-1:0] w_mask  [2];
  logic [WIDTH-1:0]  w_wdata [2];
  logic              w_inr   [2];
  logic              w_we    [2];
  logic              w_re    [2];
  logic [IDX_W-1:0]  w_idx   [2];
  logic [WIDTH-1:0]  w_rdata [2];
  logic              w_rvalid[2];

  logic              w_accept;
  logic              w_init_we;
  logic [IDX_W-1:0]  w_init_idx;
  logic              r_conflict;

  assign w_addr[0]  = RW0_addr;
  assign w_en[0]    = RW0_en;
  assign w_wmode[0] = RW0_wmode;
  assign w_mask[0]  = RW0_wmask;
  assign w_wdata[0] = RW0_wdata;
  assign w_addr[1]  = RW1_addr;
  assign w_en[1]    = RW1_en;
  assign w_wmode[1] = RW1_wmode;
  assign w_mask[1]  = RW1_wmask;
  assign w_wdata[1] = RW1_wdata;

  assign RW0_rdata   = w_rdata[0];
  assign RW0_rvalid  = w_rvalid[0];
  assign RW1_rdata   = w_rdata[1];
  assign RW1_rvalid  = w_rvalid[1];
  assign wr_conflict = r_conflict;

  assign w_accept = ~reset & ~init_busy;

`ifdef SRAM_2RW_PARAM_INIT_EN
  // ---------------------------------------------------------------------------
  // Zeroing sweep: INIT writes one word per cycle, then parks in READY.
  // ---------------------------------------------------------------------------
  typedef enum logic {ST_INIT = 1'b0, ST_READY = 1'b1} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_cnt_next;
  logic             w_busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_busy       = 1'b0;
    w_init_we    = 1'b0;
    case (r_state)
      ST_INIT: begin
        w_busy    = 1'b1;
        // Reset itself must leave memory untouched; the sweep runs only once
        // reset has been released.
        w_init_we = ~reset;
        if (r_cnt == LAST_IDX) begin
          w_state_next = ST_READY;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      ST_READY: begin
        w_busy = 1'b0;
      end
      default: begin
        w_state_next = ST_INIT;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign init_busy  = w_busy;
  assign w_init_idx = r_cnt;
`else
  assign init_busy  = 1'b0;
  assign w_init_we  = 1'b0;
  assign w_init_idx = '0;
`endif

  // ---------------------------------------------------------------------------
  // Per-port decode and read pipeline.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic [WIDTH-1:0] r_s1_data;
      logic             r_s1_valid;

      assign w_inr[gi] = ({1'b0, w_addr[gi]} < DEPTH_C);
      assign w_idx[gi] = w_addr[gi][IDX_W-1:0];
      // Out-of-range writes are dropped; out-of-range reads still complete.
      assign w_we[gi]  = w_accept & w_en[gi] & w_wmode[gi] & w_inr[gi];
      assign w_re[gi]  = w_accept & w_en[gi] & ~w_wmode[gi];

      // Stage 1 samples the array at the accepting edge (read-first with
      // respect to writes on the same edge). Data holds between reads.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_s1_data  <= '0;
          r_s1_valid <= 1'b0;
        end else begin
          r_s1_valid <= w_re[gi];
          if (w_re[gi]) begin
            r_s1_data <= w_inr[gi] ? r_mem[w_idx[gi]] : '0;
          end
        end
      end

      if (RD_LAT == 2) begin : g_lat2
        logic [WIDTH-1:0] r_s2_data;
        logic             r_s2_valid;

        always_ff @(posedge clock) begin
          if (reset) begin
            r_s2_data  <= '0;
            r_s2_valid <= 1'b0;
          end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
              r_s2_data <= r_s1_data;
            end
          end
        end

        assign w_rdata[gi]  = r_s2_data;
        assign w_rvalid[gi] = r_s2_valid;
      end else begin : g_lat1
        assign w_rdata[gi]  = r_s1_data;
        assign w_rvalid[gi] = r_s1_valid;
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Array write. RW1 is applied first and RW0 second within each granule, so
  // RW0 wins any granule both ports enable on the same word.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (w_init_we) begin
      r_mem[w_init_idx] <= '0;
    end
    for (int k = 0; k < MASK_W; k++) begin
      if (w_we[1] && w_mask[1][k]) begin
        r_mem[w_idx[1]][k*G +: G] <= w_wdata[1][k*G +: G];
      end
      if (w_we[0] && w_mask[0][k]) begin
        r_mem[w_idx[0]][k*G +: G] <= w_wdata[0][k*G +: G];
      end
    end
  end

  // Only writes that actually land are considered for a conflict.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= w_we[0] & w_we[1] & (w_addr[0] == w_addr[1]) &
                    (|(w_mask[0] & w_mask[1]));
    end
  end

endmodule

// File: tb/tb_sram_2rw_param.sv
`timescale 1ns/1ps
// Directed bench for sram_2rw_param. Two instances share every input: one
// with RD_LAT=1 and one with RD_LAT=2, both DEPTH=256 / ADDR_W=9 so that
// address 300 is out of range.
module tb_sram_2rw_param;

  logic        clock = 1'b0;
  logic        reset;
  logic [8:0]  a0, a1;
  logic        en0, en1, wm0, wm1;
  logic [3:0]  m0, m1;
  logic [35:0] d0, d1;

  logic [35:0] q1_0, q1_1, q2_0, q2_1;
  logic        v1_0, v1_1, v2_0, v2_1;
  logic        c1, c2, b1, b2;

  int errors = 0;
  int checks = 0;
  int n;

  localparam logic [35:0] ONES = 36'hF_FFFF_FFFF;

  always #5 clock = ~clock;

  sram_2rw_param #(.DEPTH(256), .WIDTH(36), .ADDR_W(9), .MASK_W(4), .RD_LAT(1)) u_dut1 (
    .clock(clock), .reset(reset), .init_busy(b1),
    .RW0_addr(a0), .RW0_en(en0), .RW0_wmode(wm0), .RW0_wmask(m0), .RW0_wdata(d0),
    .RW0_rdata(q1_0), .RW0_rvalid(v1_0),
    .RW1_addr(a1), .RW1_en(en1), .RW1_wmode(wm1), .RW1_wmask(m1), .RW1_wdata(d1),
    .RW1_rdata(q1_1), .RW1_rvalid(v1_1),
    .wr_conflict(c1)
  );

  sram_2rw_param #(.DEPTH(256), .WIDTH(36), .ADDR_W(9), .MASK_W(4), .RD_LAT(2)) u_dut2 (
    .clock(clock), .reset(reset), .init_busy(b2),
    .RW0_addr(a0), .RW0_en(en0), .RW0_wmode(wm0), .RW0_wmask(m0), .RW0_wdata(d0),
    .RW0_rdata(q2_0), .RW0_rvalid(v2_0),
    .RW1_addr(a1), .RW1_en(en1), .RW1_wmode(wm1), .RW1_wmask(m1), .RW1_wdata(d1),
    .RW1_rdata(q2_1), .RW1_rvalid(v2_1),
    .wr_conflict(c2)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle;
    en0 = 1'b0; en1 = 1'b0; wm0 = 1'b0; wm1 = 1'b0;
    m0 = '0; m1 = '0; d0 = '0; d1 = '0; a0 = '0; a1 = '0;
  endtask

  task automatic wr0(input logic [8:0] addr, input logic [35:0] data, input logic [3:0] mask);
    en0 = 1'b1; wm0 = 1'b1; a0 = addr; d0 = data; m0 = mask;
  endtask

  task automatic wr1(input logic [8:0] addr, input logic [35:0] data, input logic [3:0] mask);
    en1 = 1'b1; wm1 = 1'b1; a1 = addr; d1 = data; m1 = mask;
  endtask

  task automatic rd0(input logic [8:0] addr);
    en0 = 1'b1; wm0 = 1'b0; a0 = addr;
  endtask

  task automatic rd1(input logic [8:0] addr);
    en1 = 1'b1; wm1 = 1'b0; a1 = addr;
  endtask

  // Counts cycles with init_busy high, bounded.
  task automatic wait_ready(output int cnt);
    cnt = 0;
    while (b1 && cnt < 1000) begin
      cnt++;
      tick();
    end
  endtask

  logic [8:0]  seq_addr [4];
  logic [35:0] seq_exp  [4];

  initial begin
    idle();
    reset = 1'b1;
    repeat (3) tick();

    // Reset state
    chk("rst_rdata0_l1", q1_0, '0);
    chk("rst_rvalid1_l1", v1_1, 1'b0);
    chk("rst_rdata1_l2", q2_1, '0);
    chk("rst_rvalid0_l2", v2_0, 1'b0);
    chk("rst_conflict", c1, 1'b0);
`ifdef SRAM_2RW_PARAM_INIT_EN
    chk("rst_init_busy", b1, 1'b1);
`else
    chk("rst_init_busy", b1, 1'b0);
`endif
    reset = 1'b0;

`ifdef SRAM_2RW_PARAM_INIT_EN
    // Full sweep length, then zeroed top word
    wait_ready(n);
    chk("init_cycles", 36'(n), 36'd256);
    chk("init_busy_l2_done", b2, 1'b0);
    rd1(9'd255); tick(); idle();
    chk("init_rd255_l1", q1_1, '0);
    chk("init_rd255_v_l1", v1_1, 1'b1);
    tick();
    chk("init_rd255_l2", q2_1, '0);
    // Reset mid-sweep at counter 100 restarts from address 0
    reset = 1'b1; tick(); reset = 1'b0;
    repeat (100) tick();
    chk("mid_sweep_busy", b1, 1'b1);
    reset = 1'b1; tick(); reset = 1'b0;
    wait_ready(n);
    chk("restart_cycles", 36'(n), 36'd256);
`endif

    // A: write then read back through the other port, both latencies
    wr0(9'd5, 36'h1_2345_6789, 4'b1111); tick(); idle();
    rd1(9'd5); tick(); idle();
    chk("A_rvalid_l1", v1_1, 1'b1);
    chk("A_rdata_l1", q1_1, 36'h1_2345_6789);
    chk("A_rvalid_l2_early", v2_1, 1'b0);
    tick();
    chk("A_rvalid_l1_pulse", v1_1, 1'b0);
    chk("A_rdata_l1_hold", q1_1, 36'h1_2345_6789);
    chk("A_rvalid_l2", v2_1, 1'b1);
    chk("A_rdata_l2", q2_1, 36'h1_2345_6789);
    tick();
    chk("A_rvalid_l2_pulse", v2_1, 1'b0);

    // B: same-address dual write with overlapping masks
    wr0(9'd9, '0, 4'b1111); tick(); idle();
    wr0(9'd9, ONES, 4'b0011); wr1(9'd9, '0, 4'b1110); tick(); idle();
    chk("B_conflict_l1", c1, 1'b1);
    chk("B_conflict_l2", c2, 1'b1);
    rd0(9'd9); tick(); idle();
    chk("B_conflict_pulse", c1, 1'b0);
    chk("B_merge_l1", q1_0, 36'h0_0003_FFFF);
    tick();
    chk("B_merge_l2", q2_0, 36'h0_0003_FFFF);

    // B2: same address, disjoint masks -> merge, no conflict
    wr0(9'd10, ONES, 4'b0011); wr1(9'd10, 36'hA_AAAA_AAAA, 4'b1100); tick(); idle();
    chk("B2_no_conflict", c1, 1'b0);
    rd1(9'd10); tick(); idle();
    chk("B2_merge_l1", q1_1, 36'hA_AAAB_FFFF);

    // B3: different addresses, overlapping masks -> no conflict
    wr0(9'd11, ONES, 4'b1111); wr1(9'd12, ONES, 4'b1111); tick(); idle();
    chk("B3_no_conflict", c1, 1'b0);

    // C: read-first on a same-cycle write from the other port
    wr0(9'd3, 36'h0_0000_0AAA, 4'b1111); tick(); idle();
    wr0(9'd3, 36'h0_0000_0555, 4'b1111); rd1(9'd3); tick(); idle();
    chk("C_old_l1", q1_1, 36'h0_0000_0AAA);
    rd1(9'd3); tick(); idle();
    chk("C_new_l1", q1_1, 36'h0_0000_0555);
    chk("C_old_l2", q2_1, 36'h0_0000_0AAA);
    tick();
    chk("C_new_l2", q2_1, 36'h0_0000_0555);

    // D: out-of-range write dropped (no alias onto 44), read returns zero
    wr0(9'd44, 36'h0_0000_0111, 4'b1111); tick(); idle();
    wr0(9'd300, ONES, 4'b1111); tick(); idle();
    rd0(9'd44); tick(); idle();
    chk("D_no_alias", q1_0, 36'h0_0000_0111);
    rd0(9'd300); tick(); idle();
    chk("D_oor_rdata_l1", q1_0, '0);
    chk("D_oor_rvalid_l1", v1_0, 1'b1);
    tick();
    chk("D_oor_rdata_l2", q2_0, '0);
    chk("D_oor_rvalid_l2", v2_0, 1'b1);

    // E: partial mask on granules 0 and 2
    wr0(9'd20, '0, 4'b1111); tick();
    wr0(9'd20, ONES, 4'b0101); tick(); idle();
    rd0(9'd20); tick(); idle();
    chk("E_mask0101", q1_0, 36'h0_07FC_01FF);

    // F: back-to-back reads every cycle on RW1
    seq_addr[0] = 9'd5;  seq_exp[0] = 36'h1_2345_6789;
    seq_addr[1] = 9'd9;  seq_exp[1] = 36'h0_0003_FFFF;
    seq_addr[2] = 9'd3;  seq_exp[2] = 36'h0_0000_0555;
    seq_addr[3] = 9'd20; seq_exp[3] = 36'h0_07FC_01FF;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) rd1(seq_addr[i]);
      else idle();
      tick();
      if (i < 4) begin
        chk($sformatf("F_v_l1_%0d", i), v1_1, 1'b1);
        chk($sformatf("F_d_l1_%0d", i), q1_1, seq_exp[i]);
      end
      if (i >= 1) begin
        chk($sformatf("F_v_l2_%0d", i - 1), v2_1, 1'b1);
        chk($sformatf("F_d_l2_%0d", i - 1), q2_1, seq_exp[i-1]);
      end
    end
    idle();

    // G: reset with a read in flight, and a write presented during reset
    rd1(9'd5); tick(); idle();
    reset = 1'b1;
    wr0(9'd5, 36'h0_0000_DEAD, 4'b1111);
    tick(); idle();
    chk("G_rst_rvalid_l1", v1_1, 1'b0);
    chk("G_rst_rvalid_l2", v2_1, 1'b0);
    chk("G_rst_rdata_l2", q2_1, '0);
    chk("G_rst_rdata_l1", q1_1, '0);
    reset = 1'b0;
    tick();
    chk("G_no_late_rvalid_l2", v2_1, 1'b0);
    wait_ready(n);
    rd1(9'd5); tick(); idle(); tick();
`ifdef SRAM_2RW_PARAM_INIT_EN
    chk("G_write_in_reset_dropped", q2_1, '0);
`else
    chk("G_write_in_reset_dropped", q2_1, 36'h1_2345_6789);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
